// File: rtl/rx_packet_assembler_pkg.sv
// Shared crossbar packet types and the assembler FSM encoding.
package rx_packet_assembler_pkg;

  localparam int unsigned ports        = 4;
  localparam int unsigned packet_width = 8;

  typedef logic [packet_width-1:0] packet_t;

  typedef struct packed {
    packet_t header;
    packet_t payload;
  } full_packet_t;

  typedef enum logic [0:0] {
    StHdrWait,
    StPayWait
  } asm_state_e;

endpackage

// File: rtl/rx_packet_assembler_if.sv
// Receiver-side byte bus and record output handshake of the packet assembler.
interface rx_packet_assembler_if #(
  parameter int unsigned PORTS = rx_packet_assembler_pkg::ports,
  parameter int unsigned PKT_W = rx_packet_assembler_pkg::packet_width,
  parameter int unsigned DEPTH = 8
);

  logic                         byte_valid;
  logic                         header_phase;
  logic [PORTS*PKT_W-1:0]       rx_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [2*PORTS*PKT_W-1:0]     out_data;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport slave (
    input  byte_valid, header_phase, rx_data, out_ready,
    output out_valid, out_data, count
  );

  modport master (
    output byte_valid, header_phase, rx_data, out_ready,
    input  out_valid, out_data, count
  );

endinterface

// File: rtl/rx_asm_fifo.sv
// First-word-fall-through FIFO; data_o reads zero while empty. Depth must be a power of 2.
module rx_asm_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth+1);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == CntW'(Depth));
    do_pop   = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    do_push  = push_i && (!full_o || do_pop);
    rd_ptr_d = do_pop  ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
    data_o   = empty_o ? '0 : mem_q[rd_ptr_q];
    count_o  = count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rx_packet_assembler.sv
// Pairs per-port header/payload bytes into records and queues them in an FWFT FIFO.
// Optional macro RX_ASM_ERR_CNT_EN adds a saturating err_cnt output.
module rx_packet_assembler
  import rx_packet_assembler_pkg::*;
#(
  parameter int unsigned PORTS = ports,
  parameter int unsigned PKT_W = packet_width,
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rx_packet_assembler_if.slave  bus,
  output logic                  overflow,
`ifdef RX_ASM_ERR_CNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic                  sync_err
);

  localparam int unsigned RecW = 2*PORTS*PKT_W;

  asm_state_e             state_q, state_d;
  logic [PORTS*PKT_W-1:0] hdr_q, hdr_d;
  logic                   sync_err_q, sync_err_d;
  logic                   overflow_q, overflow_d;
  logic                   push, pop, drop, full, empty;
  logic [RecW-1:0]        rec;

  always_comb begin
    rec = '0;
    for (int i = 0; i < int'(PORTS); i++) begin
      rec[i*2*PKT_W +: 2*PKT_W] = {hdr_q[i*PKT_W +: PKT_W], bus.rx_data[i*PKT_W +: PKT_W]};
    end
  end

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    sync_err_d = 1'b0;
    push       = 1'b0;
    if (bus.byte_valid) begin
      unique case (state_q)
        StHdrWait: begin
          if (bus.header_phase) begin
            hdr_d   = bus.rx_data;
            state_d = StPayWait;
          end else begin
            sync_err_d = 1'b1;
          end
        end
        StPayWait: begin
          if (bus.header_phase) begin
            hdr_d      = bus.rx_data;
            sync_err_d = 1'b1;
          end else begin
            push    = 1'b1;
            state_d = StHdrWait;
          end
        end
        default: state_d = StHdrWait;
      endcase
    end
    pop        = !empty && bus.out_ready;
    drop       = push && full && !pop;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHdrWait;
      hdr_q      <= '0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      sync_err_q <= sync_err_d;
      overflow_q <= overflow_d;
    end
  end

  rx_asm_fifo #(
    .Width (RecW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (rec),
    .pop_i   (pop),
    .data_o  (bus.out_data),
    .count_o (bus.count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.out_valid = !empty;
  assign overflow      = overflow_q;
  assign sync_err      = sync_err_q;

`ifdef RX_ASM_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Framing errors never coincide with a push, so at most one event per cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((sync_err_d || drop) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_rx_packet_assembler.sv
// Directed self-checking bench for rx_packet_assembler (PORTS=4, PKT_W=8, DEPTH=8).
module tb_rx_packet_assembler;
  import rx_packet_assembler_pkg::*;

  localparam int unsigned Ports = 4;
  localparam int unsigned PktW  = 8;
  localparam int unsigned Depth = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic overflow, sync_err;
`ifdef RX_ASM_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  rx_packet_assembler_if #(.PORTS(Ports), .PKT_W(PktW), .DEPTH(Depth)) bus_if ();

  rx_packet_assembler #(
    .PORTS (Ports),
    .PKT_W (PktW),
    .DEPTH (Depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .overflow (overflow),
`ifdef RX_ASM_ERR_CNT_EN
    .err_cnt  (err_cnt),
`endif
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_rec(input logic [31:0] hdr, input logic [31:0] pay);
    full_packet_t fp;
    logic [63:0]  r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      fp.header  = hdr[i*8 +: 8];
      fp.payload = pay[i*8 +: 8];
      r[i*16 +: 16] = fp;
    end
    return r;
  endfunction

  // One byte strobe; returns at the falling edge after the sampling edge.
  task automatic strobe(input logic hp, input logic [31:0] d);
    @(negedge clk);
    bus_if.byte_valid   = 1'b1;
    bus_if.header_phase = hp;
    bus_if.rx_data      = d;
    @(negedge clk);
    bus_if.byte_valid   = 1'b0;
  endtask

  function automatic logic [31:0] rep(input logic [7:0] b);
    return {b, b, b, b};
  endfunction

  initial begin
    bus_if.byte_valid   = 1'b0;
    bus_if.header_phase = 1'b0;
    bus_if.rx_data      = '0;
    bus_if.out_ready    = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_count", 64'(bus_if.count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    check("rst_out_data", bus_if.out_data, 64'd0);
    rst = 1'b0;

    // Orphan payload
    strobe(1'b0, rep(8'h55));
    check("orphan_sync_err", 64'(sync_err), 64'd1);
    check("orphan_count", 64'(bus_if.count), 64'd0);
    check("orphan_valid", 64'(bus_if.out_valid), 64'd0);
    @(negedge clk);
    check("orphan_sync_err_clear", 64'(sync_err), 64'd0);

    // Header then payload, consumer ready
    bus_if.out_ready = 1'b1;
    strobe(1'b1, 32'h4433_2211);
    check("hp_hdr_sync_err", 64'(sync_err), 64'd0);
    check("hp_hdr_valid", 64'(bus_if.out_valid), 64'd0);
    strobe(1'b0, 32'hA4A3_A2A1);
    check("hp_valid", 64'(bus_if.out_valid), 64'd1);
    check("hp_data", bus_if.out_data, 64'h44A4_33A3_22A2_11A1);
    check("hp_sync_err", 64'(sync_err), 64'd0);
    @(negedge clk);
    check("hp_valid_one_cycle", 64'(bus_if.out_valid), 64'd0);
    check("hp_count", 64'(bus_if.count), 64'd0);
    check("hp_sync_err_late", 64'(sync_err), 64'd0);

    // Double header
    bus_if.out_ready = 1'b0;
    strobe(1'b1, rep(8'h10));
    check("dh_first_sync_err", 64'(sync_err), 64'd0);
    strobe(1'b1, rep(8'h20));
    check("dh_sync_err", 64'(sync_err), 64'd1);
    strobe(1'b0, rep(8'h30));
    check("dh_sync_err_once", 64'(sync_err), 64'd0);
    check("dh_data", bus_if.out_data, mk_rec(rep(8'h20), rep(8'h30)));
    check("dh_count", 64'(bus_if.count), 64'd1);
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check("dh_drained", 64'(bus_if.count), 64'd0);

    // Overflow: nine pushes into eight slots
    for (int k = 1; k <= 9; k++) begin
      strobe(1'b1, rep(8'(k)));
      strobe(1'b0, rep(8'hB0 + 8'(k)));
      if (k == 8) begin
        check("ovf_count8", 64'(bus_if.count), 64'd8);
        check("ovf_not_yet", 64'(overflow), 64'd0);
      end
    end
    check("ovf_count", 64'(bus_if.count), 64'd8);
    check("ovf_flag", 64'(overflow), 64'd1);
`ifdef RX_ASM_ERR_CNT_EN
    check("ovf_err_cnt", 64'(err_cnt), 64'd3);
`endif
    bus_if.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("ovf_drain_valid%0d", k), 64'(bus_if.out_valid), 64'd1);
      check($sformatf("ovf_drain_data%0d", k), bus_if.out_data,
            mk_rec(rep(8'(k)), rep(8'hB0 + 8'(k))));
      @(negedge clk);
    end
    bus_if.out_ready = 1'b0;
    check("ovf_empty", 64'(bus_if.count), 64'd0);
    check("ovf_empty_data", bus_if.out_data, 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Mid-record asynchronous reset
    strobe(1'b1, rep(8'h01));
    strobe(1'b0, rep(8'h02));
    strobe(1'b1, rep(8'h03));
    check("mr_pre_count", 64'(bus_if.count), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_valid", 64'(bus_if.out_valid), 64'd0);
    check("mr_count", 64'(bus_if.count), 64'd0);
    check("mr_data", bus_if.out_data, 64'd0);
    check("mr_overflow", 64'(overflow), 64'd0);
`ifdef RX_ASM_ERR_CNT_EN
    check("mr_err_cnt_clr", 64'(err_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    strobe(1'b0, rep(8'h77));
    check("mr_sync_err", 64'(sync_err), 64'd1);
    check("mr_no_push", 64'(bus_if.count), 64'd0);
`ifdef RX_ASM_ERR_CNT_EN
    check("mr_err_cnt", 64'(err_cnt), 64'd1);
`endif

    // Full boundary: push and pop together at count 8
    for (int k = 1; k <= 8; k++) begin
      strobe(1'b1, rep(8'(k)));
      strobe(1'b0, rep(8'hC0 + 8'(k)));
    end
    check("fb_count8", 64'(bus_if.count), 64'd8);
    strobe(1'b1, rep(8'h09));
    @(negedge clk);
    bus_if.byte_valid   = 1'b1;
    bus_if.header_phase = 1'b0;
    bus_if.rx_data      = rep(8'hC9);
    bus_if.out_ready    = 1'b1;
    check("fb_head_before", bus_if.out_data, mk_rec(rep(8'h01), rep(8'hC1)));
    @(negedge clk);
    bus_if.byte_valid   = 1'b0;
    bus_if.out_ready    = 1'b0;
    check("fb_count_kept", 64'(bus_if.count), 64'd8);
    check("fb_no_overflow", 64'(overflow), 64'd0);
    bus_if.out_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("fb_drain_data%0d", k), bus_if.out_data,
            mk_rec(rep(8'(k)), rep(8'hC0 + 8'(k))));
      @(negedge clk);
    end
    bus_if.out_ready = 1'b0;
    check("fb_empty", 64'(bus_if.count), 64'd0);
    check("fb_overflow_final", 64'(overflow), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
